// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // 50 MHz system clock, 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/uart_rx_fifo_feeder_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 UART receiver feeding a byte FIFO, with sticky framing/overrun flags.
// Optional parity bit and parity_err flag when UART_RX_PARITY_EN is defined.
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned CNT_W        = 16
`ifdef UART_RX_PARITY_EN
  ,parameter bit         PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  input  logic       err_clr,
  output logic       fifo_wr,
  output logic [7:0] fifo_data,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err
`ifdef UART_RX_PARITY_EN
  ,output logic      parity_err
`endif
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       shift_reg, shift_nx;
  logic             rx_s, rx_s_d, fall;
  logic             wr_nx, set_frame, set_over;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign fall = rx_s_d & ~rx_s;
  assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nx, set_par;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNT_W'(1);
    bit_nx    = bit_idx;
    shift_nx  = shift_reg;
    wr_nx     = 1'b0;
    set_frame = 1'b0;
    set_over  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx = par_bad;
    set_par    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (fall) state_nx = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          bit_nx = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          shift_nx = {rx_s, shift_reg[7:1]};
          bit_nx   = bit_idx + 3'd1;
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nx     = '0;
          par_bad_nx = ((^shift_reg) ^ rx_s) != PARITY_ODD;
          set_par    = par_bad_nx;
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          // Stop sample ends the frame half a bit early so back-to-back frames are not missed.
          if (!rx_s) begin
            set_frame = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            wr_nx = 1'b0;
`endif
          end else if (fifo_full) begin
            set_over = 1'b1;
          end else begin
            wr_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      rx_s_d      <= 1'b1;
      fifo_wr     <= 1'b0;
      fifo_data   <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      rx_s_d  <= rx_s;
      fifo_wr <= wr_nx;
      if (wr_nx) fifo_data <= shift_reg;
      // Sticky flags: a set in the same cycle as err_clr takes priority.
      if (set_frame)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (set_over)     overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nx;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad <= par_bad_nx;
      if (set_par)      parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Self-checking bench for uart_rx_fifo_feeder at CLKS_PER_BIT=8: directed cases plus random frames.
module tb_uart_rx_fifo_feeder;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst, rx, fifo_full, err_clr;
  logic       fifo_wr, busy, frame_err, overrun_err;
  logic [7:0] fifo_data;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_count = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] exp_q[$];
  logic       exp_frame = 1'b0, exp_over = 1'b0, exp_par = 1'b0;

  uart_rx_fifo_feeder #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .fifo_full   (fifo_full),
    .err_clr     (err_clr),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
    ,.parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest byte the model says should be delivered.
  always @(negedge clk) begin
    if (rst === 1'b1 && fifo_wr === 1'b1) begin
      wr_count++;
      last_data = fifo_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wr: got data %0h, expected no write at %0t", fifo_data, $time);
      end else begin
        check("wr_data", {24'h0, fifo_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Model: a frame is delivered iff stop is high, parity good and FIFO not full.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    logic bad_par;
    bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par = par_flip;
`endif
    if (stop_bit && !bad_par && !fifo_full) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
    if (!stop_bit) exp_frame = 1'b1;
    if (bad_par) exp_par = 1'b1;
    if (stop_bit && !bad_par && fifo_full) exp_over = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr   = 1'b0;
    exp_frame = 1'b0;
    exp_over  = 1'b0;
    exp_par   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, exp_frame});
    check({tag, "_overrun_err"}, {31'h0, overrun_err}, {31'h0, exp_over});
`ifdef UART_RX_PARITY_EN
    check({tag, "_parity_err"}, {31'h0, parity_err}, {31'h0, exp_par});
`endif
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic check_reset_values();
    check("rst_fifo_wr", {31'h0, fifo_wr}, 32'h0);
    check("rst_fifo_data", {24'h0, fifo_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun_err", {31'h0, overrun_err}, 32'h0);
  endtask

  initial begin
    int  w0, gap;
    logic prev_stop;
    logic [7:0] b;
    logic sb, pf;

    rst = 1'b0; rx = 1'b1; fifo_full = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;
    idle_gap(2 * C);

    // Single good byte
    w0 = wr_count;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_count", wr_count - w0, 1);
    check("a5_data", {24'h0, last_data}, 32'hA5);
    check_state("a5");

    // Back-to-back frames, no idle between stop and next start
    w0 = wr_count;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check("b2b_count", wr_count - w0, 2);
    check("b2b_last", {24'h0, last_data}, 32'hFF);
    check_state("b2b");

    // Short glitch is a false start
    w0 = wr_count;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_start", {31'h0, busy}, 32'h1);
    idle_gap(2 * C);
    check("glitch_count", wr_count - w0, 0);
    check_state("glitch");

    // Framing error then clear
    w0 = wr_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_gap(C);
    check("frame_count", wr_count - w0, 0);
    check("frame_set", {31'h0, frame_err}, 32'h1);
    check_state("frame");
    pulse_clr();
    check("frame_clr", {31'h0, frame_err}, 32'h0);

    // Overrun, then good byte with flag still sticky
    w0 = wr_count;
    fifo_full = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    check("ovr_count", wr_count - w0, 0);
    check("ovr_set", {31'h0, overrun_err}, 32'h1);
    fifo_full = 1'b0;
    send_frame(8'h81, 1'b1, 1'b0);
    check("ovr_count2", wr_count - w0, 1);
    check("ovr_data", {24'h0, last_data}, 32'h81);
    check("ovr_sticky", {31'h0, overrun_err}, 32'h1);
    check_state("ovr");
    pulse_clr();
    check("ovr_clr", {31'h0, overrun_err}, 32'h0);

    // Reset in the middle of a frame of 0x5A
    w0 = wr_count;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;
    exp_frame = 1'b0; exp_over = 1'b0; exp_par = 1'b0;
    idle_gap(2 * C);
    send_frame(8'h12, 1'b1, 1'b0);
    check("rstmid_count", wr_count - w0, 1);
    check("rstmid_data", {24'h0, last_data}, 32'h12);
    check_state("rstmid");

`ifdef UART_RX_PARITY_EN
    w0 = wr_count;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_count", wr_count - w0, 0);
    check("par_set", {31'h0, parity_err}, 32'h1);
    check_state("par");
    pulse_clr();
`endif

    // Random frames
    prev_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pf = 1'b0;
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 5) == 0);
`endif
      fifo_full = ($urandom_range(0, 3) == 0);
      gap = prev_stop ? $urandom_range(0, C) : C;
      if (gap > 0) idle_gap(gap);
      send_frame(b, sb, pf);
      prev_stop = sb;
      check_state("rnd");
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    fifo_full = 1'b0;
    idle_gap(2 * C);
    check("pending_bytes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
